// File: rtl/row_scan_decoder.sv
// Registered N-row scan sequencer for the LED panel: blanks between rows, drives
// active-low row selects and output-enable, in auto-dwell or advance-paced mode.
module row_scan_decoder #(
  parameter int ADDR_W       = 3,
  parameter int BLANK_CYCLES = 2,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     auto_mode,
  input  logic                     advance,
  input  logic [ADDR_W-1:0]        man_addr,
  output logic [(1<<ADDR_W)-1:0]   y_n,
  output logic [ADDR_W-1:0]        row_addr,
  output logic                     oe_n,
  output logic                     frame_start,
  output logic                     busy
);

  localparam int ROWS = 1 << ADDR_W;
  localparam int BW   = $clog2(BLANK_CYCLES) + 1;
  localparam int DW   = $clog2(DWELL_CYCLES) + 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [ROWS-1:0]   y_n_q, y_n_d;
  logic              oe_n_q, oe_n_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic              row_exit;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bcnt_d   = bcnt_q;
    dcnt_d   = dcnt_q;
    row_exit = 1'b0;

    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        dcnt_d = '0;
        if (en) begin
          state_d = S_BLANK;
          row_d   = auto_mode ? '0 : man_addr;
        end
      end
      S_BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          state_d = S_ACTIVE;
          bcnt_d  = '0;
          dcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        // Mode is only looked at here, so a mid-row change applies at this row's exit.
        if (auto_mode) begin
          if (dcnt_q == DWELL_LAST) begin
            row_exit = 1'b1;
            row_d    = row_q + 1'b1;
          end
        end else if (advance) begin
          row_exit = 1'b1;
          row_d    = man_addr;
        end
        if (row_exit) begin
          state_d = S_BLANK;
          bcnt_d  = '0;
          dcnt_d  = '0;
        end else if (dcnt_q != DWELL_LAST) begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      dcnt_d  = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet cycle-aligned.
  always_comb begin
    y_n_d  = '1;
    oe_n_d = 1'b1;
    busy_d = (state_d != S_IDLE);
    fs_d   = 1'b0;
    if (state_d == S_ACTIVE) begin
      y_n_d[row_d] = 1'b0;
      oe_n_d       = 1'b0;
      fs_d         = (state_q == S_BLANK) && (row_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      y_n_q   <= '1;
      oe_n_q  <= 1'b1;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      y_n_q   <= y_n_d;
      oe_n_q  <= oe_n_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign y_n         = y_n_q;
  assign row_addr    = row_q;
  assign oe_n        = oe_n_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_row_scan_decoder.sv
// Directed bench for row_scan_decoder: each expected lit row (pattern, frame_start,
// dwell length) is queued by the stimulus and checked when that row goes dark.
module tb_row_scan_decoder;

  localparam int ADDR_W = 3;
  localparam int ROWS   = 8;
  localparam int BLANK  = 2;
  localparam int W      = ROWS + 1 + 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              auto_mode;
  logic              advance;
  logic [ADDR_W-1:0] man_addr;
  logic [ROWS-1:0]   y_n;
  logic [ADDR_W-1:0] row_addr;
  logic              oe_n;
  logic              frame_start;
  logic              busy;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  row_scan_decoder #(
    .ADDR_W(ADDR_W),
    .BLANK_CYCLES(BLANK),
    .DWELL_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .auto_mode(auto_mode),
    .advance(advance),
    .man_addr(man_addr),
    .y_n(y_n),
    .row_addr(row_addr),
    .oe_n(oe_n),
    .frame_start(frame_start),
    .busy(busy)
  );

  // Clock and reset-time setup
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int r, input logic fs, input int d);
    logic [ROWS-1:0] y;
    y    = '1;
    y[r] = 1'b0;
    exp_q.push_back({y, fs, 8'(d)});
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic            mon_on;
  logic            lit;
  logic [ROWS-1:0] y_start;
  logic            fs_first;
  int              dwell;
  int              fs_extra;
  logic            y_chg;
  int              blank_run;

  initial begin
    mon_on    = 1'b0;
    lit       = 1'b0;
    y_start   = '1;
    fs_first  = 1'b0;
    dwell     = 0;
    fs_extra  = 0;
    y_chg     = 1'b0;
    blank_run = 0;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ($countones(~y_n) > 1 || ((oe_n == 1'b0) != ($countones(~y_n) == 1))) begin
        bad++;
        $display("FAIL onehot_oe: y_n=%b oe_n=%b", y_n, oe_n);
      end
      if (!oe_n) begin
        if (!lit) begin
          lit      = 1'b1;
          y_start  = y_n;
          fs_first = frame_start;
          dwell    = 1;
          fs_extra = 0;
          y_chg    = 1'b0;
          total++;
          if (blank_run != BLANK) begin
            bad++;
            $display("FAIL blank_gap: got %0d want %0d before y_n=%b", blank_run, BLANK, y_n);
          end
        end else begin
          dwell++;
          if (frame_start) fs_extra++;
          if (y_n != y_start) y_chg = 1'b1;
        end
        blank_run = 0;
      end else begin
        if (lit) begin
          logic [W-1:0] e;
          logic [W-1:0] a;
          lit = 1'b0;
          a   = {y_start, fs_first, 8'(dwell)};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL row_unexpected: got y/fs/dwell=%h want none", a);
          end else begin
            e = exp_q.pop_front();
            if (a != e || fs_extra != 0 || y_chg) begin
              bad++;
              $display("FAIL row: got y/fs/dwell=%h fs_extra=%0d y_chg=%b want %h", a, fs_extra, y_chg, e);
            end
          end
        end
        if (frame_start) begin
          total++;
          bad++;
          $display("FAIL fs_dark: got frame_start=1 want 0 while oe_n=1");
        end
        blank_run = busy ? blank_run + 1 : 0;
      end
    end
  end

  // Stimulus
  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    auto_mode = 1'b1;
    advance   = 1'b0;
    man_addr  = '0;
    tick(3);
    check("rst_y_n", 16'(y_n), 16'h00ff);
    check("rst_oe_n", 16'(oe_n), 16'd1);
    check("rst_row", 16'(row_addr), 16'd0);
    check("rst_fs", 16'(frame_start), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    tick(1);

    // Auto: one full frame, then frame 2 rows 0..2, en dropped 4 cycles into row 3
    for (int r = 0; r < ROWS; r++) push_row(r, r == 0, 8);
    for (int r = 0; r < 3; r++) push_row(r, r == 0, 8);
    push_row(3, 1'b0, 4);
    en = 1'b1;
    tick(116);
    en = 1'b0;
    tick(1);
    check("endrop_y_n", 16'(y_n), 16'h00ff);
    check("endrop_oe_n", 16'(oe_n), 16'd1);
    check("endrop_busy", 16'(busy), 16'd0);
    check("endrop_row_hold", 16'(row_addr), 16'd3);
    tick(2);

    // Auto restart at row 0, switch to manual mid-row, then advance-paced rows
    push_row(0, 1'b1, 10);
    push_row(5, 1'b0, 20);
    push_row(0, 1'b1, 3);
    push_row(6, 1'b0, 1);
    push_row(7, 1'b0, 5);
    en = 1'b1;
    tick(5);  auto_mode = 1'b0;
    tick(7);  advance = 1'b1; man_addr = 3'd5;
    tick(2);  advance = 1'b0;
    tick(11);
    check("man_row5_y_n", 16'(y_n), 16'h00df);
    check("man_row5_addr", 16'(row_addr), 16'd5);
    tick(9);  advance = 1'b1; man_addr = 3'd0;
    tick(1);  advance = 1'b0;
    tick(4);  advance = 1'b1; man_addr = 3'd6;
    tick(1);  advance = 1'b0;
    tick(2);  advance = 1'b1; man_addr = 3'd7;
    tick(1);  advance = 1'b0;
    tick(6);  en = 1'b0;
    tick(1);
    check("man_idle_row", 16'(row_addr), 16'd7);
    check("man_idle_busy", 16'(busy), 16'd0);
    tick(3);

    // Reset mid-BLANK with advance high; auto run resumes from row 0
    push_row(0, 1'b1, 8);
    push_row(1, 1'b0, 2);
    en = 1'b1; man_addr = 3'd4;
    tick(1);
    check("blank_row4", 16'(row_addr), 16'd4);
    check("blank_busy", 16'(busy), 16'd1);
    rst_n = 1'b0; advance = 1'b1;
    tick(1);
    check("midrst_y_n", 16'(y_n), 16'h00ff);
    check("midrst_oe_n", 16'(oe_n), 16'd1);
    check("midrst_row", 16'(row_addr), 16'd0);
    check("midrst_fs", 16'(frame_start), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1; advance = 1'b0; auto_mode = 1'b1;
    tick(14); en = 1'b0;
    tick(6);

    check("exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
